elastic_skid_fifo: RTL and testbench

//  Parametrised multi-entry successor to the 2-entry skid buffer: a DEPTH-entry valid/ready elastic buffer.

---
 rtl/skid_pkg.sv | 13 +
 rtl/skid_ptr_ctr.sv | 29 ++
 rtl/elastic_skid_fifo.sv | 122 ++++++++++++
 tb/tb_elastic_skid_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared definitions for the elastic skid FIFO slice.
// DROP_CNT_W sizes the optional overwrite counter that is enabled by the
// ELASTIC_SKID_FIFO_DROP_CNT_EN macro in elastic_skid_fifo.
package skid_pkg;

    localparam int DROP_CNT_W = 32;

    // Next pointer value, wrapping from depth-1 back to 0 so any depth works
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/skid_ptr_ctr.sv
// Wrapping pointer counter used for both the read and write pointers of
// elastic_skid_fifo. Counts 0..DEPTH-1 and wraps, so DEPTH need not be a
// power of two.
module skid_ptr_ctr
    import skid_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Advance the pointer by one slot when enabled, cleared asynchronously
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= PTR_W'(ptr_inc(32'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/elastic_skid_fifo.sv
// DEPTH-entry valid/ready elastic buffer. ready_in and valid_out are both
// registered, so there is no combinational path from ready_out to ready_in.
// CIRCULAR_BUFFER_MODE=1 never stalls the input and overwrites the oldest
// entry when full. Defining ELASTIC_SKID_FIFO_DROP_CNT_EN adds the
// saturating drop_count output that counts those overwrites.
module elastic_skid_fifo
    import skid_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int DEPTH                = 4,
    parameter int CIRCULAR_BUFFER_MODE = 0,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam bit IS_CIRC = (CIRCULAR_BUFFER_MODE != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [LVL_W-1:0]      r_level;
    logic [LVL_W-1:0]      w_levelNext;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_overflow;
    logic [PTR_W-1:0]      w_rdPtr;
    logic [PTR_W-1:0]      w_wrPtr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_overwrite;

    assign w_push = valid_in & r_ready;
    assign w_pop  = r_valid & ready_out;
    assign w_full = (r_level == FULL_LVL);

    // A full push without a pop in circular mode drops the oldest entry;
    // a same-cycle pop frees a slot, so that case is an ordinary transfer.
    assign w_overwrite = IS_CIRC & w_push & ~w_pop & w_full;

    // Occupancy update: +1 on push, -1 on pop, held on overwrite
    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop && !w_overwrite) begin
            w_levelNext = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - LVL_W'(1);
        end
    end

    // Control registers; ready/valid come from next-state so they are pure flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_level    <= w_levelNext;
            r_valid    <= (w_levelNext != '0);
            r_ready    <= IS_CIRC ? 1'b1 : (w_levelNext < FULL_LVL);
            r_overflow <= w_overwrite;
        end
    end

    // Storage array, written on every accepted push and never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wrPtr] <= data_in;
        end
    end

    skid_ptr_ctr #(.DEPTH(DEPTH)) u_rdPtr (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (w_pop | w_overwrite),
        .ptr   (w_rdPtr)
    );

    skid_ptr_ctr #(.DEPTH(DEPTH)) u_wrPtr (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (w_push),
        .ptr   (w_wrPtr)
    );

    assign ready_in  = r_ready;
    assign valid_out = r_valid;
    assign data_out  = r_mem[w_rdPtr];
    assign level     = r_level;
    assign overflow  = r_overflow;

`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_dropCount;

    // Count overwrites since reset, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropCount <= '0;
        end else if (w_overwrite && (r_dropCount != '1)) begin
            r_dropCount <= r_dropCount + DROP_CNT_W'(1);
        end
    end

    assign drop_count = r_dropCount;
`endif

endmodule

// File: tb/tb_elastic_skid_fifo.sv
// Bench for elastic_skid_fifo. Three instances share one stimulus stream:
// index 0 = DEPTH 4 lossless, 1 = DEPTH 4 circular, 2 = DEPTH 3 lossless.
// A queue-based reference model runs alongside every cycle, and directed
// tables/sequences carry hand-computed values for the corner cases.
// Build with ELASTIC_SKID_FIFO_DROP_CNT_EN defined to cover drop_count.
module tb_elastic_skid_fifo;

    logic       clk;
    logic       rst_n;
    logic       vin;
    logic       rout;
    logic [7:0] din;

    logic       rdyS  [3];
    logic       vldS  [3];
    logic       ovfS  [3];
    logic [7:0] dataS [3];
    logic [2:0] lvl0;
    logic [2:0] lvl1;
    logic [1:0] lvl2;
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
    logic [31:0] dropS [3];
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state per instance
    logic [7:0] mq [3][$];
    bit         mReady [3];
    bit         mValid [3];
    bit         mOvf   [3];
    int         mDrop  [3];

    typedef struct {
        logic       vin;
        logic [7:0] din;
        logic       rout;
        logic       e0r;
        int         e0l;
        logic [7:0] e0d;
        int         e1l;
        logic       e1o;
        logic [7:0] e1d;
        logic       e2r;
        int         e2l;
        logic [7:0] e2d;
    } vec_t;

    vec_t tbl [11];

    elastic_skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .CIRCULAR_BUFFER_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin), .ready_in(rdyS[0]),
        .data_out(dataS[0]), .valid_out(vldS[0]), .ready_out(rout), .level(lvl0),
        .overflow(ovfS[0])
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
        , .drop_count(dropS[0])
`endif
    );

    elastic_skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .CIRCULAR_BUFFER_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin), .ready_in(rdyS[1]),
        .data_out(dataS[1]), .valid_out(vldS[1]), .ready_out(rout), .level(lvl1),
        .overflow(ovfS[1])
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
        , .drop_count(dropS[1])
`endif
    );

    elastic_skid_fifo #(.DATA_WIDTH(8), .DEPTH(3), .CIRCULAR_BUFFER_MODE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin), .ready_in(rdyS[2]),
        .data_out(dataS[2]), .valid_out(vldS[2]), .ready_out(rout), .level(lvl2),
        .overflow(ovfS[2])
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
        , .drop_count(dropS[2])
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int depthOf(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic bit circOf(input int i);
        return (i == 1);
    endfunction

    function automatic logic [31:0] getLevel(input int i);
        case (i)
            0:       return 32'(lvl0);
            1:       return 32'(lvl1);
            default: return 32'(lvl2);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mdlReset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mReady[i] = 1'b0;
            mValid[i] = 1'b0;
            mOvf[i]   = 1'b0;
            mDrop[i]  = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelEdge();
        for (int i = 0; i < 3; i++) begin
            bit push;
            bit pop;
            push    = vin & mReady[i];
            pop     = mValid[i] & rout;
            mOvf[i] = 1'b0;
            if (pop) void'(mq[i].pop_front());
            if (push) begin
                if (circOf(i) && (mq[i].size() == depthOf(i))) begin
                    void'(mq[i].pop_front());
                    mOvf[i] = 1'b1;
                    if (mDrop[i] != -1) mDrop[i]++;
                end
                mq[i].push_back(din);
            end
            mValid[i] = (mq[i].size() != 0);
            mReady[i] = circOf(i) ? 1'b1 : (mq[i].size() < depthOf(i));
        end
    endtask

    task automatic modelCheck();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("mdl_ready[%0d]", i), 32'(rdyS[i]), 32'(mReady[i]));
            checkOutput($sformatf("mdl_valid[%0d]", i), 32'(vldS[i]), 32'(mValid[i]));
            checkOutput($sformatf("mdl_level[%0d]", i), getLevel(i), 32'(mq[i].size()));
            checkOutput($sformatf("mdl_ovf[%0d]", i), 32'(ovfS[i]), 32'(mOvf[i]));
            if (mValid[i]) begin
                checkOutput($sformatf("mdl_data[%0d]", i), 32'(dataS[i]), 32'(mq[i][0]));
            end
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
            checkOutput($sformatf("mdl_drop[%0d]", i), dropS[i], mDrop[i]);
`endif
        end
    endtask

    task automatic stepCycle();
        modelEdge();
        @(posedge clk);
        #1;
        modelCheck();
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        vin  = v;
        din  = d;
        rout = r;
        stepCycle();
    endtask

    initial begin
        // Fill, overwrite, full push+pop, then drain; values after each edge
        //            vin  din    rout  e0r e0l e0d    e1l e1o e1d    e2r e2l e2d
        tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1, 8'hA0, 1, 1'b0, 8'hA0, 1'b1, 1, 8'hA0};
        tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 2, 8'hA0, 2, 1'b0, 8'hA0, 1'b1, 2, 8'hA0};
        tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 3, 8'hA0, 3, 1'b0, 8'hA0, 1'b0, 3, 8'hA0};
        tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 4, 8'hA0, 4, 1'b0, 8'hA0, 1'b0, 3, 8'hA0};
        tbl[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 4, 8'hA0, 4, 1'b1, 8'hA1, 1'b0, 3, 8'hA0};
        tbl[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4, 8'hA0, 4, 1'b1, 8'hA2, 1'b0, 3, 8'hA0};
        tbl[6]  = '{1'b1, 8'hA6, 1'b1, 1'b1, 3, 8'hA1, 4, 1'b0, 8'hA3, 1'b1, 2, 8'hA1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2, 8'hA2, 3, 1'b0, 8'hA4, 1'b1, 1, 8'hA2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 8'hA3, 2, 1'b0, 8'hA5, 1'b1, 0, 8'h00};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1, 1'b0, 8'hA6, 1'b1, 0, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 0, 1'b0, 8'h00, 1'b1, 0, 8'h00};

        rst_n = 1'b0;
        vin   = 1'b0;
        rout  = 1'b0;
        din   = 8'h00;
        mdlReset();

        // Reset values while rst_n is held low
        #2;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_ready[%0d]", i), 32'(rdyS[i]), 32'd0);
            checkOutput($sformatf("rst_valid[%0d]", i), 32'(vldS[i]), 32'd0);
            checkOutput($sformatf("rst_level[%0d]", i), getLevel(i), 32'd0);
            checkOutput($sformatf("rst_ovf[%0d]", i), 32'(ovfS[i]), 32'd0);
        end

        // Release away from an edge; ready_in rises on the next edge
        @(posedge clk);
        #3 rst_n = 1'b1;
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("first_ready[%0d]", i), 32'(rdyS[i]), 32'd1);
        end

        // Directed table
        for (int r = 0; r < 11; r++) begin
            applyStimulus(tbl[r].vin, tbl[r].din, tbl[r].rout);
            checkOutput($sformatf("t%0d_ready0", r), 32'(rdyS[0]), 32'(tbl[r].e0r));
            checkOutput($sformatf("t%0d_level0", r), getLevel(0), tbl[r].e0l);
            checkOutput($sformatf("t%0d_valid0", r), 32'(vldS[0]), 32'(tbl[r].e0l != 0));
            if (tbl[r].e0l != 0) checkOutput($sformatf("t%0d_data0", r), 32'(dataS[0]), 32'(tbl[r].e0d));
            checkOutput($sformatf("t%0d_level1", r), getLevel(1), tbl[r].e1l);
            checkOutput($sformatf("t%0d_ovf1", r), 32'(ovfS[1]), 32'(tbl[r].e1o));
            if (tbl[r].e1l != 0) checkOutput($sformatf("t%0d_data1", r), 32'(dataS[1]), 32'(tbl[r].e1d));
            checkOutput($sformatf("t%0d_ready2", r), 32'(rdyS[2]), 32'(tbl[r].e2r));
            checkOutput($sformatf("t%0d_level2", r), getLevel(2), tbl[r].e2l);
            if (tbl[r].e2l != 0) checkOutput($sformatf("t%0d_data2", r), 32'(dataS[2]), 32'(tbl[r].e2d));
        end
`ifdef ELASTIC_SKID_FIFO_DROP_CNT_EN
        checkOutput("drop_circ", dropS[1], 32'd2);
        checkOutput("drop_lossless", dropS[0], 32'd0);
`endif

        // Streaming at full rate: word k is at the head one cycle after its push
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b1);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("stream%0d_level[%0d]", k, i), getLevel(i), 32'd1);
                checkOutput($sformatf("stream%0d_data[%0d]", k, i), 32'(dataS[i]), 32'(k));
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("stream_drained", getLevel(0), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 10000; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);
        end

        // Drain, load three words, then reset mid-stream
        for (int n = 0; n < 6; n++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'hB0, 1'b0);
        applyStimulus(1'b1, 8'hB1, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0);
        checkOutput("pre_rst_level0", getLevel(0), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("midrst_valid[%0d]", i), 32'(vldS[i]), 32'd0);
            checkOutput($sformatf("midrst_level[%0d]", i), getLevel(i), 32'd0);
            checkOutput($sformatf("midrst_ready[%0d]", i), 32'(rdyS[i]), 32'd0);
        end
        mdlReset();
        vin = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("release_ready[%0d]", i), 32'(rdyS[i]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
